// File: rtl/miner_job_ctrl.sv
// Job controller for a hashing miner core: accepts a job, starts the miner,
// tracks the nonce sweep, and reports FOUND / EXHAUSTED / ABORTED / BADJOB.
module miner_job_ctrl #(
  parameter int unsigned LOOP_LOG2   = 5,
  parameter int unsigned TAIL_CYCLES = 8
) (
  input  logic         hash_clk,
  input  logic         reset_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] job_midstate,
  input  logic [95:0]  job_data,
  input  logic [31:0]  job_nonce_min,
  input  logic [31:0]  job_nonce_max,
  input  logic         abort,
  output logic [255:0] miner_midstate,
  output logic [95:0]  miner_work_data,
  output logic [31:0]  miner_nonce_min,
  output logic [31:0]  miner_nonce_max,
  output logic         miner_reset,
  input  logic [31:0]  miner_golden_nonce,
  input  logic         miner_new_golden,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic [1:0]   res_status,
  output logic         busy
);

  localparam int unsigned PW = (LOOP_LOG2 == 0) ? 1 : LOOP_LOG2;
  localparam logic [PW-1:0] PHASE_LAST = PW'((1 << LOOP_LOG2) - 1);
  localparam logic [31:0]   DRAIN_INIT = 32'(2 * (1 << LOOP_LOG2) + TAIL_CYCLES);

  localparam logic [1:0] ST_FOUND     = 2'b00;
  localparam logic [1:0] ST_EXHAUSTED = 2'b01;
  localparam logic [1:0] ST_ABORTED   = 2'b10;
  localparam logic [1:0] ST_BADJOB    = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, REPORT} state_t;

  state_t        r_state;
  logic [255:0]  r_midstate;
  logic [95:0]   r_data;
  logic [31:0]   r_min;
  logic [31:0]   r_max;
  logic          r_mreset;
  logic [31:0]   r_tracker;
  logic [PW-1:0] r_phase;
  logic [31:0]   r_drain;
  logic [1:0]    r_hold;
  logic [31:0]   r_res_nonce;
  logic [1:0]    r_res_status;

  logic w_golden_ok;
  logic w_phase_last;

  // Golden results are honoured only after the RUN holdoff, and only in range.
  always_comb begin
    w_golden_ok = miner_new_golden
               && ((r_state == RUN && r_hold == 2'd0) || r_state == DRAIN)
               && (miner_golden_nonce >= r_min)
               && (miner_golden_nonce <= r_max);
    w_phase_last = (r_phase == PHASE_LAST);
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_midstate   <= '0;
      r_data       <= '0;
      r_min        <= '0;
      r_max        <= '0;
      r_mreset     <= 1'b0;
      r_tracker    <= '0;
      r_phase      <= '0;
      r_drain      <= '0;
      r_hold       <= '0;
      r_res_nonce  <= '0;
      r_res_status <= '0;
    end else begin
      r_mreset <= 1'b0;
      case (r_state)
        IDLE: begin
          if (job_valid) begin
            r_midstate <= job_midstate;
            r_data     <= job_data;
            r_min      <= job_nonce_min;
            r_max      <= job_nonce_max;
            r_tracker  <= job_nonce_min;
            r_phase    <= '0;
            r_drain    <= '0;
            r_hold     <= '0;
            if (job_nonce_max < job_nonce_min) begin
              r_state      <= REPORT;
              r_res_status <= ST_BADJOB;
              r_res_nonce  <= job_nonce_min;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            r_state      <= REPORT;
            r_res_status <= ST_ABORTED;
            r_res_nonce  <= r_tracker;
          end else begin
            r_state  <= START;
            r_mreset <= 1'b1;
          end
        end
        START: begin
          if (abort) begin
            r_state      <= REPORT;
            r_res_status <= ST_ABORTED;
            r_res_nonce  <= r_tracker;
          end else begin
            r_state <= RUN;
            r_phase <= '0;
            r_hold  <= 2'd2;
          end
        end
        RUN: begin
          if (abort) begin
            r_state      <= REPORT;
            r_res_status <= ST_ABORTED;
            r_res_nonce  <= r_tracker;
          end else if (w_golden_ok) begin
            r_state      <= REPORT;
            r_res_status <= ST_FOUND;
            r_res_nonce  <= miner_golden_nonce;
          end else begin
            if (r_hold != 2'd0) r_hold <= r_hold - 2'd1;
            if (w_phase_last) begin
              r_phase <= '0;
              // Stop on the last nonce instead of incrementing, so max=0xFFFFFFFF never wraps.
              if (r_tracker == r_max) begin
                r_state <= DRAIN;
                r_drain <= DRAIN_INIT;
              end else begin
                r_tracker <= r_tracker + 32'd1;
              end
            end else begin
              r_phase <= r_phase + PW'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            r_state      <= REPORT;
            r_res_status <= ST_ABORTED;
            r_res_nonce  <= r_tracker;
          end else if (w_golden_ok) begin
            r_state      <= REPORT;
            r_res_status <= ST_FOUND;
            r_res_nonce  <= miner_golden_nonce;
          end else begin
            r_drain <= r_drain - 32'd1;
            if (r_drain == 32'd1) begin
              r_state      <= REPORT;
              r_res_status <= ST_EXHAUSTED;
              r_res_nonce  <= r_max;
            end
          end
        end
        REPORT: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign job_ready       = (r_state == IDLE);
  assign busy            = (r_state != IDLE);
  assign res_valid       = (r_state == REPORT);
  assign res_nonce       = r_res_nonce;
  assign res_status      = r_res_status;
  assign miner_midstate  = r_midstate;
  assign miner_work_data = r_data;
  assign miner_nonce_min = r_min;
  assign miner_nonce_max = r_max;
  assign miner_reset     = r_mreset;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Randomized self-checking bench for miner_job_ctrl; the reference model predicts
// each job's outcome from the job timeline (accept, RUN start, nonce sweep, drain).
module tb_miner_job_ctrl;
  localparam int LG   = 1;
  localparam int TAIL = 8;
  localparam int L    = 1 << LG;
  localparam int D    = 2 * L + TAIL;

  logic         hash_clk = 1'b0;
  logic         reset_n;
  logic         job_valid;
  logic         job_ready;
  logic [255:0] job_midstate;
  logic [95:0]  job_data;
  logic [31:0]  job_nonce_min;
  logic [31:0]  job_nonce_max;
  logic         abort;
  logic [255:0] miner_midstate;
  logic [95:0]  miner_work_data;
  logic [31:0]  miner_nonce_min;
  logic [31:0]  miner_nonce_max;
  logic         miner_reset;
  logic [31:0]  miner_golden_nonce;
  logic         miner_new_golden;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic [1:0]   res_status;
  logic         busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  miner_job_ctrl #(.LOOP_LOG2(LG), .TAIL_CYCLES(TAIL)) dut (
    .hash_clk(hash_clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_midstate(job_midstate),
    .job_data(job_data), .job_nonce_min(job_nonce_min), .job_nonce_max(job_nonce_max),
    .abort(abort),
    .miner_midstate(miner_midstate), .miner_work_data(miner_work_data),
    .miner_nonce_min(miner_nonce_min), .miner_nonce_max(miner_nonce_max),
    .miner_reset(miner_reset),
    .miner_golden_nonce(miner_golden_nonce), .miner_new_golden(miner_new_golden),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
    .res_status(res_status), .busy(busy)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One job from acceptance (cycle 0) to one cycle past the result handshake.
  // g*c: cycle of a golden pulse (-1 none), abc: abort cycle (-1 none), rd: res_ready delay.
  task automatic run_job(input logic [31:0] mn, input logic [31:0] mx,
                         input int g1c, input logic [31:0] g1n,
                         input int g2c, input logic [31:0] g2n,
                         input int abc, input int rd);
    longint       n_nonce;
    int           r_cyc;
    logic [1:0]   e_st;
    logic [31:0]  e_nn;
    logic [31:0]  gn;
    longint       k;
    logic [255:0] e_mid;
    logic [95:0]  e_dat;

    n_nonce = longint'({32'b0, mx}) - longint'({32'b0, mn}) + 1;
    if (mx < mn) begin
      r_cyc = 1; e_st = 2'b11; e_nn = mn;
    end else begin
      r_cyc = 3 + int'(n_nonce) * L + D;
      e_st  = 2'b01; e_nn = mx;
      for (int c = 1; c < 3 + int'(n_nonce) * L + D; c++) begin
        if (c == abc) begin
          k = (c < 3) ? 0 : longint'((c - 3) / L);
          if (k > n_nonce - 1) k = n_nonce - 1;
          r_cyc = c + 1; e_st = 2'b10; e_nn = mn + 32'(k);
          break;
        end
        gn = (c == g1c) ? g1n : g2n;
        if ((c == g1c || c == g2c) && c >= 5 && gn >= mn && gn <= mx) begin
          r_cyc = c + 1; e_st = 2'b00; e_nn = gn;
          break;
        end
      end
    end

    e_mid = rand256();
    e_dat = rand256()[95:0];
    for (int c = 0; c <= r_cyc + rd + 1; c++) begin
      @(negedge hash_clk);
      if (c == 0) begin
        check("accept_ready", {255'b0, job_ready}, 256'd1);
        job_midstate = e_mid; job_data = e_dat;
        job_nonce_min = mn; job_nonce_max = mx;
      end else begin
        job_midstate = rand256(); job_data = rand256()[95:0];
        job_nonce_min = $urandom; job_nonce_max = $urandom;
      end
      job_valid          = (c == 0);
      miner_new_golden   = (c == g1c) || (c == g2c);
      miner_golden_nonce = (c == g1c) ? g1n : ((c == g2c) ? g2n : $urandom);
      abort              = (c == abc);
      res_ready          = (c == r_cyc + rd);

      if (c > 0) check("miner_reset", {255'b0, miner_reset}, {255'b0, (c == 2 && r_cyc > 2)});
      if (c == 1) begin
        check("cfg_midstate", miner_midstate, e_mid);
        check("cfg_data", {160'b0, miner_work_data}, {160'b0, e_dat});
        check("cfg_min", {224'b0, miner_nonce_min}, {224'b0, mn});
        check("cfg_max", {224'b0, miner_nonce_max}, {224'b0, mx});
      end
      if (c > 0 && c < r_cyc) begin
        check("run_valid", {255'b0, res_valid}, 256'd0);
        check("run_busy", {255'b0, busy}, 256'd1);
        check("run_ready", {255'b0, job_ready}, 256'd0);
      end else if (c >= r_cyc && c <= r_cyc + rd) begin
        check("rep_valid", {255'b0, res_valid}, 256'd1);
        check("rep_nonce", {224'b0, res_nonce}, {224'b0, e_nn});
        check("rep_status", {254'b0, res_status}, {254'b0, e_st});
        check("rep_ready", {255'b0, job_ready}, 256'd0);
        if (c == r_cyc) check("rep_midstate", miner_midstate, e_mid);
      end else if (c > r_cyc + rd) begin
        check("post_ready", {255'b0, job_ready}, 256'd1);
        check("post_valid", {255'b0, res_valid}, 256'd0);
      end
    end
    job_valid = 1'b0; abort = 1'b0; miner_new_golden = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    int          seen;
    logic [31:0] mn;
    logic [31:0] mx;
    int          span;
    int          g1c, g2c, abc;
    logic [31:0] g1n, g2n;

    reset_n = 1'b0; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    miner_new_golden = 1'b0; miner_golden_nonce = '0;
    job_midstate = '0; job_data = '0; job_nonce_min = '0; job_nonce_max = '0;
    #1;
    check("rst_ready", {255'b0, job_ready}, 256'd1);
    check("rst_busy", {255'b0, busy}, 256'd0);
    check("rst_valid", {255'b0, res_valid}, 256'd0);
    check("rst_mreset", {255'b0, miner_reset}, 256'd0);
    repeat (2) @(negedge hash_clk);
    reset_n = 1'b1;

    run_job(32'h10, 32'h1F, 40, 32'h15, -1, 0, -1, 0);
    run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, -1, 0, -1, 0);
    run_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, 0, -1, 0, -1, 1);
    run_job(32'h20, 32'h1F, -1, 0, -1, 0, -1, 2);
    run_job(32'h10, 32'h1F, 3, 32'h12, 10, 32'h50, -1, 0);
    run_job(32'h10, 32'h1F, 12, 32'h14, -1, 0, 12, 5);
    run_job(32'h100, 32'h102, -1, 0, -1, 0, 1, 0);
    run_job(32'h100, 32'h102, -1, 0, -1, 0, 2, 0);
    run_job(32'h100, 32'h103, 5, 32'h101, -1, 0, -1, 0);
    run_job(32'h100, 32'h100, 4, 32'h100, -1, 0, -1, 0);
    run_job(32'h100, 32'h100, -1, 0, -1, 0, 10, 1);

    // Reset asserted mid-DRAIN: job discarded, no result, controller reusable.
    @(negedge hash_clk);
    job_valid = 1'b1; job_midstate = rand256(); job_nonce_min = 32'h5; job_nonce_max = 32'h5;
    @(negedge hash_clk);
    job_valid = 1'b0;
    repeat (7) @(negedge hash_clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {255'b0, busy}, 256'd0);
    check("mid_rst_ready", {255'b0, job_ready}, 256'd1);
    check("mid_rst_valid", {255'b0, res_valid}, 256'd0);
    check("mid_rst_mid", miner_midstate, 256'd0);
    check("mid_rst_max", {224'b0, miner_nonce_max}, 256'd0);
    check("mid_rst_nonce", {224'b0, res_nonce}, 256'd0);
    @(negedge hash_clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge hash_clk);
      if (res_valid) seen++;
    end
    check("mid_rst_noresult", 256'(seen), 256'd0);
    run_job(32'h40, 32'h42, 8, 32'h41, -1, 0, -1, 1);

    for (int j = 0; j < 40; j++) begin
      mn   = 32'h100 + $urandom_range(0, 32'h7FFF_FFFF);
      span = $urandom_range(0, 4);
      mx   = ($urandom_range(0, 7) == 0) ? mn - 32'($urandom_range(1, 16)) : mn + 32'(span);
      g1c  = $urandom_range(1, 30);
      g1n  = $urandom_range(0, 1) ? mn + 32'($urandom_range(0, span)) : mn + 32'(span + 1 + $urandom_range(0, 9));
      g2c  = $urandom_range(0, 1) ? $urandom_range(1, 30) : -1;
      g2n  = $urandom_range(0, 1) ? mn + 32'($urandom_range(0, span)) : mn - 32'($urandom_range(1, 9));
      abc  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
      run_job(mn, mx, g1c, g1n, g2c, g2n, abc, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/miner_job_ctrl.md
MINER_JOB_CTRL -- requirements
Module: miner_job_ctrl

Interface
REQ-001 SHALL have parameter LOOP_LOG2, default 5, meaning the miner unroll setting; cycles per nonce L = 2^LOOP_LOG2, valid range 0..5.
REQ-002 SHALL have parameter TAIL_CYCLES, default 8, meaning extra drain cycles after the last nonce is issued.
REQ-003 SHALL have port hash_clk  in  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have job_valid in 1, job_ready out 1, job_midstate in 256, job_data in 96, job_nonce_min in 32, job_nonce_max in 32: job submission, valid/ready.
REQ-006 SHALL have abort  in  1  cancel the current job.
REQ-007 SHALL have miner_midstate out 256, miner_work_data out 96, miner_nonce_min out 32, miner_nonce_max out 32, miner_reset out 1: miner configuration and start.
REQ-008 SHALL have miner_golden_nonce in 32, miner_new_golden in 1: miner result.
REQ-009 SHALL have res_valid out 1, res_ready in 1, res_nonce out 32, res_status out 2: result, valid/ready.
REQ-010 SHALL have busy  out  1  high when state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, LOAD, START, RUN, DRAIN, REPORT.
REQ-012 job_ready SHALL equal (state==IDLE); on job_valid&&job_ready all job fields SHALL be registered into the miner_* outputs and the state SHALL go to LOAD.
REQ-013 If job_nonce_max < job_nonce_min at acceptance, SHALL go directly to REPORT with res_status=2'b11 (BADJOB), res_nonce=job_nonce_min.
REQ-014 LOAD SHALL last exactly 1 cycle, then START; miner_* config outputs SHALL stay stable from LOAD until the next accepted job.
REQ-015 miner_reset SHALL be 1 during exactly the single START cycle and 0 otherwise; START -> RUN.
REQ-016 In RUN, SHALL keep a phase counter (0..L-1, wraps) and a nonce tracker starting at nonce_min, incremented when phase==L-1.
REQ-017 Exhaustion: when tracker==nonce_max and phase==L-1, SHALL go to DRAIN without incrementing the tracker (no 32-bit wrap at 0xFFFFFFFF), loading a drain counter with 2*L+TAIL_CYCLES.
REQ-018 DRAIN SHALL decrement the drain counter each cycle; at 0, go to REPORT with res_status=2'b01 (EXHAUSTED), res_nonce=nonce_max.
REQ-019 miner_new_golden SHALL be ignored in the first 2 cycles of RUN (holdoff for stale pulses from a prior job) and in every state other than RUN/DRAIN.
REQ-020 Outside the holdoff in RUN/DRAIN, a miner_new_golden with nonce_min <= miner_golden_nonce <= nonce_max SHALL produce REPORT on the next cycle with res_status=2'b00 (FOUND), res_nonce=miner_golden_nonce; an out-of-range golden nonce SHALL be ignored.
REQ-021 abort in LOAD, START, RUN or DRAIN SHALL go to REPORT next cycle with res_status=2'b10 (ABORTED), res_nonce=current tracker (nonce_min if RUN not yet entered); abort in IDLE or REPORT SHALL be ignored.
REQ-022 Priority in the same cycle: abort > FOUND > exhaustion/drain expiry.
REQ-023 In REPORT, res_valid SHALL be 1 and res_nonce/res_status held stable until res_valid&&res_ready, then IDLE; res_valid SHALL be 0 in all other states.
REQ-024 A job SHALL be acceptable in the cycle after the REPORT handshake (job_ready=1 in IDLE).

Reset
REQ-025 reset_n low SHALL asynchronously force state IDLE, miner_reset=0, res_valid=0, res_nonce=0, res_status=0, busy=0, all miner_* config outputs 0, all counters 0; job_ready thus reads 1.
REQ-026 reset_n low mid-job SHALL discard the job with no result reported.

Verification
REQ-027 LOOP_LOG2=5, job min=0x10 max=0x1F accepted at cycle T -> miner_reset high only at T+2; golden 0x15 pulsed at T+40 -> res_valid at T+41, nonce 0x15, status 00.
REQ-028 LOOP_LOG2=1, min=max=0xFFFFFFFF, no golden -> tracker never wraps, REPORT after 2 RUN cycles + 2*2+8 DRAIN cycles, status 01, nonce 0xFFFFFFFF.
REQ-029 min=0x20 max=0x1F -> REPORT one cycle after accept, status 11, miner_reset never asserted.
REQ-030 Golden pulse in first RUN cycle, then golden 0x50 outside [0x10,0x1F] -> both ignored, job reaches EXHAUSTED.
REQ-031 abort and in-range golden in the same RUN cycle -> status 10; res_ready held 0 for 5 cycles -> res_valid/res_nonce stable, job_ready 0 throughout.
REQ-032 reset_n pulsed low during DRAIN -> outputs at reset values immediately, no res_valid, next job accepted normally.
